// File: rtl/uart_tx_mmio_if.sv
// Register bus between the CPU side and the UART transmitter.
//   we    : write strobe, one access per cycle
//   re    : read strobe, only qualifies rdata
//   addr  : word offset (0 = TXDATA, 1 = STATUS, 2-3 reserved)
//   wdata : write data
//   rdata : combinational read data, 0 when re is low
interface uart_tx_mmio_if;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output we,
    output re,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  re,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : register bus (slave side)
//   tx       : serial line, idle high, registered
//   busy     : a frame is on the line
//   tx_empty : FIFO empty and shifter idle
// Registers: 0 = TXDATA (write pushes wdata[7:0], reads 0),
//            1 = STATUS {ovf, busy, empty, full}; writing bit3 = 1 clears ovf.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_mmio_if.slave   bus,
  output logic            tx,
  output logic            busy,
  output logic            tx_empty
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [DivW-1:0] DivMax  = DivW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  localparam logic [1:0] AddrTxData = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;

  // Shifter
  state_e          state_q;
  logic [DivW-1:0] div_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic            tx_q;

  logic fifo_full, fifo_empty;
  logic wr_txdata, wr_status;
  logic push, pop, bit_done;
  logic [7:0] head;

  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  assign wr_txdata = bus.we && (bus.addr == AddrTxData);
  assign wr_status = bus.we && (bus.addr == AddrStatus);

  // Fullness is judged on the count before the edge, so a push into a full
  // FIFO is dropped even when the shifter pops on the same edge.
  assign push     = wr_txdata && !fifo_full;
  assign bit_done = (div_q == DivMax);

  // The shifter takes the head whenever it is idle, or at the end of a stop
  // bit so that consecutive frames run with no idle gap.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !fifo_empty;
      StStop:  pop = bit_done && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_txdata && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr_status && bus.wdata[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q <= StStart;
            shreg_q <= head;
            div_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q <= StData;
            div_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shreg_q[0];
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StData: begin
          if (bit_done) begin
            div_q   <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              // Next bit is the one about to land in bit0 after the shift.
              tx_q <= shreg_q[1];
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_done) begin
            div_q <= '0;
            if (!fifo_empty) begin
              state_q <= StStart;
              shreg_q <= head;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          div_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle);
  assign tx_empty = fifo_empty && (state_q == StIdle);

  always_comb begin
    bus.rdata = '0;
    if (bus.re && (bus.addr == AddrStatus)) begin
      bus.rdata = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
    end
  end

  // Only the byte lane and the ovf-clear bit carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
  localparam int unsigned Cpb      = 4;
  localparam int unsigned Depth    = 4;
  localparam int          FrameLen = 10 * Cpb;

  logic clk = 1'b0;
  logic rst;
  logic tx, busy, tx_empty;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tx      (tx),
    .busy    (busy),
    .tx_empty(tx_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending bytes plus the frame currently on the
  // line, tracked as a time offset into a 10-bit 8N1 frame.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_t;
  bit         m_ovf;

  function automatic void model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_ovf    = 1'b0;
    m_cur    = 8'h00;
  endfunction

  function automatic logic [31:0] m_status();
    return {28'd0, m_ovf, m_active, m_q.size() == 0, m_q.size() == Depth};
  endfunction

  function automatic logic m_tx();
    int pos;
    if (!m_active) return 1'b1;
    pos = m_t / Cpb;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
    return 1'b1;
  endfunction

  function automatic void m_clock(bit we, logic [1:0] addr, logic [31:0] wdata);
    bit full_pre = (m_q.size() == Depth);
    bit ne_pre   = (m_q.size() != 0);
    if (m_active) begin
      if (m_t == FrameLen - 1) begin
        m_sent.push_back(m_cur);
        if (ne_pre) begin
          m_cur = m_q.pop_front();
          m_t   = 0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_t++;
      end
    end else if (ne_pre) begin
      m_active = 1'b1;
      m_cur    = m_q.pop_front();
      m_t      = 0;
    end
    if (we && addr == 2'd0) begin
      if (full_pre) m_ovf = 1'b1;
      else m_q.push_back(wdata[7:0]);
    end else if (we && addr == 2'd1 && wdata[3]) begin
      m_ovf = 1'b0;
    end
  endfunction

  // Independent line decoder: samples mid-bit on falling clock edges.
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (!rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      for (int i = 0; i < 8; i++) begin
        if (rx_cnt == Cpb * (i + 1) + Cpb / 2) rx_byte[i] = tx;
      end
      if (rx_cnt == 9 * Cpb + Cpb / 2) begin
        check("rx_stop", tx, 1'b1);
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  // One bus cycle, entered and left at a falling clock edge.
  task automatic bus_cycle(input bit we, input bit re, input logic [1:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd);
    bus.we    = we;
    bus.re    = re;
    bus.addr  = addr;
    bus.wdata = wdata;
    #1;
    rd = bus.rdata;
    check("rdata", rd, (re && addr == 2'd1) ? m_status() : 32'd0);
    @(posedge clk);
    if (!rst) model_reset();
    else m_clock(we, addr, wdata);
    #1;
    check("line", {tx, busy, tx_empty},
          {m_tx(), m_active, (!m_active && m_q.size() == 0)});
    @(negedge clk);
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 2'd0, 32'd0, rd);
  endtask

  task automatic write(input logic [1:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    bus_cycle(1'b1, 1'b0, addr, wdata, rd);
  endtask

  task automatic read(input logic [1:0] addr, output logic [31:0] rd);
    bus_cycle(1'b0, 1'b1, addr, 32'd0, rd);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_active || m_q.size() != 0) && guard < (Depth + 2) * FrameLen + 10) begin
      idle(1);
      guard++;
    end
    check("drain_done", tx_empty, 1'b1);
  endtask

  task automatic wait_model_t(input int t);
    int guard = 0;
    while (!(m_active && m_t == t) && guard < 2 * FrameLen) begin
      idle(1);
      guard++;
    end
    check("wait_frame_pos", (m_active && m_t == t), 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [39:0] got_stream, exp_stream;
    logic [9:0]  frame;
    int          busy_cnt;
    int          rx_before;

    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'd0;
    rst       = 1'b0;
    model_reset();

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    rst = 1'b1;
    read(2'd1, rd);
    check("reset_status", rd, 32'h2);
    check("reset_pins", {tx, busy, tx_empty}, 3'b101);
    idle(50);
    check("idle_tx", tx, 1'b1);

    // Single byte 0xA5
    write(2'd0, 32'hA5);
    check("tx_after_write", tx, 1'b1);
    frame    = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    for (int i = 0; i < FrameLen; i++) begin
      idle(1);
      got_stream[i] = tx;
      exp_stream[i] = frame[i/Cpb];
      if (busy) busy_cnt++;
    end
    idle(1);
    if (busy) busy_cnt++;
    check("a5_stream", got_stream, exp_stream);
    check("a5_busy_cycles", busy_cnt, FrameLen);
    check("a5_tx_empty", tx_empty, 1'b1);

    // Back-to-back
    busy_cnt = 0;
    write(2'd0, 32'h55); if (busy) busy_cnt++;
    write(2'd0, 32'h0F); if (busy) busy_cnt++;
    write(2'd0, 32'hFF); if (busy) busy_cnt++;
    for (int i = 0; i < 3 * FrameLen + 5; i++) begin
      idle(1);
      if (busy) busy_cnt++;
    end
    check("b2b_busy_cycles", busy_cnt, 3 * FrameLen);
    check("b2b_rx_count", rx_q.size(), 4);
    if (rx_q.size() >= 3) begin
      check("b2b_rx0", rx_q[rx_q.size()-3], 8'h55);
      check("b2b_rx1", rx_q[rx_q.size()-2], 8'h0F);
      check("b2b_rx2", rx_q[rx_q.size()-1], 8'hFF);
    end

    // Overflow
    rx_before = rx_q.size();
    for (int i = 0; i < 6; i++) write(2'd0, 32'($urandom_range(0, 255)));
    read(2'd1, rd);
    check("ovf_status", rd, 32'hD);
    write(2'd1, 32'h8);
    read(2'd1, rd);
    check("ovf_cleared", rd, 32'h5);
    drain();
    idle(2);
    check("ovf_rx_count", rx_q.size() - rx_before, 5);

    // Reserved addresses
    write(2'd2, $urandom());
    write(2'd3, $urandom());
    read(2'd2, rd);
    check("rsv2_read", rd, 32'd0);
    read(2'd3, rd);
    check("rsv3_read", rd, 32'd0);
    read(2'd0, rd);
    check("txdata_read", rd, 32'd0);
    read(2'd1, rd);
    check("rsv_status", rd, 32'h2);

    // Push coinciding with end of stop bit, FIFO at 3/4
    for (int i = 0; i < 4; i++) write(2'd0, 32'($urandom_range(0, 255)));
    wait_model_t(FrameLen - 1);
    read(2'd1, rd);
    check("sim_pre_status", rd, 32'h4);
    write(2'd0, 32'h99);
    read(2'd1, rd);
    check("sim_post_status", rd, 32'h4);
    check("sim_model_count", m_q.size(), 3);
    drain();
    idle(2);

    // Reset during data bit 3 of 0x3C with two bytes queued
    rx_before = rx_q.size();
    write(2'd0, 32'h3C);
    write(2'd0, 32'h11);
    write(2'd0, 32'h22);
    wait_model_t(4 * Cpb + 1);
    #3 rst = 1'b0;
    #1 check("async_rst_tx_bit3", tx, 1'b1);
    model_reset();
    @(negedge clk);
    idle(2);
    rst = 1'b1;
    read(2'd1, rd);
    check("post_rst_status", rd, 32'h2);
    idle(100);
    check("post_rst_no_frames", rx_q.size() - rx_before, 0);

    // Reset during a start bit, where tx is low
    write(2'd0, 32'h00);
    wait_model_t(1);
    check("start_bit_low", tx, 1'b0);
    #3 rst = 1'b0;
    #1 check("async_rst_tx_start", tx, 1'b1);
    model_reset();
    @(negedge clk);
    idle(2);
    rst = 1'b1;
    idle(5);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned op = $urandom_range(0, 99);
      if (op < 30) write(2'd0, $urandom());
      else if (op < 35) write(2'd1, $urandom());
      else if (op < 40) write(2'($urandom_range(2, 3)), $urandom());
      else if (op < 60) read(2'($urandom_range(0, 3)), rd);
      else idle(1);
    end
    drain();
    idle(3);

    check("rx_total", rx_q.size(), m_sent.size());
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++) begin
      check("rx_byte", rx_q[i], m_sent[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter peripheral on the spoc data bus. The CPU writes bytes into a small FIFO through a register interface, and the block serialises them as 8N1 frames on `tx`. It is the outbound path from the SoC to the simulation bench and off-chip console: the bench drives `clk`/`rst` into spoc, and this block drives characters back out. Register reads expose FIFO and shifter status, so firmware can poll before writing.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal values are ≥ 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries. Must be a power of 2, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `we` in 1: bus write strobe, one access per cycle it is high.
- `re` in 1: bus read strobe. Reads have no side effects; `re` only qualifies `rdata`.
- `addr` in 2: word offset. 0 = TXDATA, 1 = STATUS, 2–3 reserved.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data for the current `addr`. It is 0 when `re` = 0.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is on the line (shifter not in IDLE).
- `tx_empty` out 1: high when the FIFO is empty and the shifter is IDLE (all data sent).

## Operation
- **TXDATA write** (`we`, `addr` = 0): pushes `wdata[7:0]`.
  - If the FIFO is full (count before the edge = `FIFO_DEPTH`), the byte is dropped and sticky `ovf` is set. This holds even if a pop happens in the same cycle.
  - Reading TXDATA returns 0.
- **STATUS read**: bit0 = full, bit1 = empty (FIFO), bit2 = busy, bit3 = `ovf`, bits 31:4 = 0.
- **STATUS write**: `wdata[3]` = 1 clears `ovf`; other bits are ignored. If an overflowing push and a clear occur in the same cycle, that is impossible (one access per cycle).
- **Reserved addresses**: writes are ignored; reads return 0.
- **FIFO**: circular buffer, read/write pointers wrap modulo `FIFO_DEPTH`, with a count register of width log2(`FIFO_DEPTH`)+1. A push and a pop in the same cycle (FIFO not full) leave the count unchanged.
- **Shifter FSM**: states IDLE, START, DATA, STOP.
  - A bit counter (baud divider) counts 0..`CLKS_PER_BIT`-1.
  - A 3-bit index tracks the data bit.
- **Transitions**:
  - IDLE → START when FIFO is not empty: pop the head into the shift register and clear the divider.
  - START → DATA after `CLKS_PER_BIT` cycles, index = 0.
  - DATA: after each `CLKS_PER_BIT` cycles, shift right and increment the index. After the bit with index 7 → STOP.
  - STOP → START (pop in the same edge) if FIFO is not empty after `CLKS_PER_BIT` cycles, else → IDLE.
- **Line values**: `tx` = 1 in IDLE/STOP, 0 in START, and the shift register bit0 in DATA. Data is sent LSB first. `tx` is registered.

## Timing
- **Reset values**: `tx` = 1, `busy` = 0, `tx_empty` = 1, `ovf` = 0, FIFO empty (pointers and count 0), FSM IDLE, divider 0, `rdata` = 0.
- **Reset mid-frame**: `tx` returns to 1 immediately (asynchronously). The frame is aborted and the FIFO contents are discarded.
- **Latency**:
  - Write accepted at edge k; FIFO is non-empty after k.
  - Pop and IDLE→START at edge k+1; `tx` falls after edge k+1.
- **Frame length**: exactly 10 × `CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- **Back-to-back bytes**: no idle gap. The next start bit begins at the edge that ends the previous stop bit.
- **`busy`**: rises with the `tx` fall and drops at the edge where STOP → IDLE.
- **`tx_empty`**: goes 0 in the cycle after a write is accepted.
- **Status reads**: STATUS reflects register state before the current edge. A write and a read cannot coincide in the same access.

## Test plan
- **Reset and idle**: hold `rst` = 0 for 3 cycles, release → `tx` = 1, STATUS reads 0x2, `tx_empty` = 1, `busy` = 0. Then 50 cycles with no writes → `tx` stays 1.
- **Single byte**: `CLKS_PER_BIT` = 4, write 0xA5 to addr 0.
  - Bit stream, LSB first, each bit held 4 cycles: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1.
  - `tx` falls 1 edge after the write; `busy` is high for 40 cycles; `tx_empty` = 1 afterwards.
- **Back-to-back**: write 0x55, 0x0F, 0xFF on consecutive cycles → three frames, 120 cycles total. No high gap between a stop bit and the next start bit; decoded bytes arrive in order.
- **Overflow**: with the shifter stalled on frame 1 and `FIFO_DEPTH` = 4, issue 6 writes.
  - The first 5 are accepted (1 popped, 4 queued); the 6th is dropped.
  - STATUS = 0xD (full, busy, ovf).
  - Write STATUS with `wdata` = 0x8 → `ovf` = 0.
  - Only 5 bytes appear on `tx`.
- **Reset mid-frame**: assert `rst` during DATA bit 3 of 0x3C with 2 bytes queued. `tx` = 1 within the same cycle (async). After release, STATUS = 0x2 and no further frames are sent.
- **Reserved and simultaneous**: write to addr 2/3 → no effect, read returns 0. Write TXDATA while STOP completes with FIFO at 3/4 → the push and pop both occur, the count stays 3, and there is no overflow.
